// File: rtl/rcs32_clk_if.sv
// Handshake and data bundle for the slice-serial 32-bit subtractor.
// The master side issues the request and operands; the slave side
// returns the status pulses and the held result.
interface rcs32_clk_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              bi;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] d;
    logic              bo;
    logic              ov;

    modport master (
        output start, a, b, bi,
        input  busy, done, d, bo, ov
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, d, bo, ov
    );
endinterface

// File: rtl/rcs32_clk.sv
// Slice-serial ripple-borrow subtractor: d = a - b - bi.
// One SLICE_W-bit subtract cell is reused each clock, LSB slice first,
// with the borrow held in a register between slices.
module rcs32_clk #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    rcs32_clk_if.slave   bus
);
    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB    = DATA_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic               borrow;
    logic [DATA_W-1:0]  d_q;
    logic               bo_q;
    logic               ov_q;
    logic               busy_q;
    logic               done_q;
    logic [SLICE_W:0]   slice_res;

    // Unsigned slice subtract with borrow-in; the extra top bit of the
    // result is the borrow-out (the widened difference went negative).
    function automatic logic [SLICE_W:0] sub_slice(
        input logic [SLICE_W-1:0] x,
        input logic [SLICE_W-1:0] y,
        input logic               bin
    );
        return {1'b0, x} - {1'b0, y} - {{SLICE_W{1'b0}}, bin};
    endfunction

    assign slice_res = sub_slice(a_q[cnt*SLICE_W +: SLICE_W],
                                 b_q[cnt*SLICE_W +: SLICE_W],
                                 borrow);

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.bo   = bo_q;
    assign bus.ov   = ov_q;

    // Control FSM and slice datapath; reset abandons any pass in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            borrow <= 1'b0;
            d_q    <= '0;
            bo_q   <= 1'b0;
            ov_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        borrow <= bus.bi;
                        cnt    <= '0;
                        d_q    <= '0;
                        busy_q <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    d_q[cnt*SLICE_W +: SLICE_W] <= slice_res[SLICE_W-1:0];
                    borrow <= slice_res[SLICE_W];
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(NSLICE - 1)) begin
                        // Last slice holds the result MSB, so overflow is
                        // decided from this slice's top difference bit.
                        bo_q   <= slice_res[SLICE_W];
                        ov_q   <= (a_q[MSB] ^ b_q[MSB]) &
                                  (slice_res[SLICE_W-1] ^ a_q[MSB]);
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
